// File: rtl/uart_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_feeder
// Description : Packet staging stage in front of the 64-bit UART transmitter.
//               Buffers outbound packets in a small circular FIFO. Presents
//               one packet at a time on tx_data with a load strobe, and
//               follows tx_busy so that a frame is never reloaded mid-send.
//               Optional odd parity in the MSB is enabled by defining
//               UART_TX_FEEDER_PARITY_EN.
// Ports       : txclk, reset_n (async, active-low)
//               pkt_in/pkt_valid/pkt_ready   - upstream packet push
//               tx_enable/tx_busy            - transmitter status inputs
//               tx_data/ld_tx_data/tx_done   - transmitter load interface
//               fifo_count/empty/half/full   - FIFO status
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_feeder #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             txclk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pkt_in,
  input  logic             pkt_valid,
  output logic             pkt_ready,
  input  logic             tx_enable,
  input  logic             tx_busy,
  output logic [WIDTH-1:0] tx_data,
  output logic             ld_tx_data,
  output logic             tx_done,
  output logic [CW-1:0]    fifo_count,
  output logic             fifo_empty,
  output logic             fifo_half,
  output logic             fifo_full
);

  localparam int c_AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD      = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_SENDING   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              w_ld_next;
  logic              w_done_next;
  logic              w_pop;
  logic              w_push;

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW-1:0]   r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [WIDTH-1:0]  w_head;
  logic [WIDTH-1:0]  w_load_data;

  // ---------------------------------------------------------------------------
  // FIFO status. A full FIFO refuses a push even if a pop happens that cycle.
  // ---------------------------------------------------------------------------
  assign fifo_count = r_count;
  assign fifo_empty = (r_count == '0);
  assign fifo_full  = (r_count == CW'(DEPTH));
  assign fifo_half  = (r_count >= CW'(DEPTH / 2));
  assign pkt_ready  = !fifo_full;
  assign w_push     = pkt_valid && pkt_ready;

  assign w_head = r_mem[r_rd_ptr];

`ifdef UART_TX_FEEDER_PARITY_EN
  // XNOR-reduce of the payload makes the total number of ones odd.
  assign w_load_data = {~^w_head[WIDTH-2:0], w_head[WIDTH-2:0]};
`else
  assign w_load_data = w_head;
`endif

  // Storage array carries no reset; occupancy is tracked by r_count.
  always_ff @(posedge txclk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= pkt_in;
    end
  end

  // Pointers are c_AW bits wide, so they wrap at DEPTH (a power of 2).
  always_ff @(posedge txclk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Load FSM: state and registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge txclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      ld_tx_data <= 1'b0;
      tx_done    <= 1'b0;
      tx_data    <= '0;
    end else begin
      r_state    <= w_state_next;
      ld_tx_data <= w_ld_next;
      tx_done    <= w_done_next;
      if (w_pop) begin
        tx_data <= w_load_data;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ld_next    = 1'b0;
    w_done_next  = 1'b0;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!fifo_empty && tx_enable && !tx_busy) begin
          w_pop        = 1'b1;
          w_ld_next    = 1'b1;
          w_state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        // The transmitter only sees the strobe on an enabled cycle, so the
        // strobe stays up across gated cycles.
        if (tx_enable) begin
          w_state_next = S_WAIT_BUSY;
        end else begin
          w_ld_next = 1'b1;
        end
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          w_state_next = S_SENDING;
        end
      end
      S_SENDING: begin
        if (!tx_busy) begin
          w_done_next  = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire
